imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: the loader FSM state
// encoding and the default values for the memory depth and frame start marker.
// No ports (package).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int unsigned DEPTH_DEFAULT      = 256;
    localparam logic [7:0]  START_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CNT_HI = 4'd1,
        CNT_LO = 4'd2,
        W_HI   = 4'd3,
        W_LO   = 4'd4,
        WR     = 4'd5,
        CHK    = 4'd6,
        DONE   = 4'd7,
        ERR    = 4'd8
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a framed program image over a valid/ready byte stream and writes it
// into instruction memory as 16-bit words, holding the processor in reset until
// a frame with a good checksum has been loaded.
//
// Frame: START_BYTE, count hi, count lo, N words (high byte first), checksum.
// Checksum = XOR of both count bytes and every word byte.
//
// Ports
//   clk        in   clock, all state changes on rising edge
//   reset      in   asynchronous active-low reset
//   rx_valid   in   byte-source data valid
//   rx_data    in   byte-source data [7:0]
//   rx_ready   out  loader accepts a byte this cycle (low only while writing)
//   imem_we    out  instruction-memory write strobe
//   imem_addr  out  instruction-memory word address [15:0]
//   imem_wdata out  instruction word to write [15:0]
//   cpu_hold   out  holds the processor in reset while high
//   done       out  last frame loaded with good checksum
//   error      out  last frame rejected
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEFAULT,
    parameter logic [7:0]  START_BYTE = START_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_count;
    logic [16:0] r_idx;      // one bit wider so idx==N is representable at N=DEPTH
    logic [7:0]  r_csum;
    logic [7:0]  r_hi;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic        w_ready;
    logic        w_xfer;
    logic        w_start;
    logic [15:0] w_count;
    logic [16:0] w_idx_next;

    assign w_ready    = (r_state != WR);
    assign w_xfer     = rx_valid & w_ready;
    assign w_start    = w_xfer & (rx_data == START_BYTE);
    assign w_count    = {r_count[15:8], rx_data};
    assign w_idx_next = r_idx + 17'd1;

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------- next state / outputs
    always_comb begin
        w_state_next = r_state;
        rx_ready     = w_ready;
        imem_we      = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_hold     = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_start) w_state_next = CNT_HI;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (w_start) w_state_next = CNT_HI;
            end
            ERR: begin
                error = 1'b1;
                if (w_start) w_state_next = CNT_HI;
            end
            CNT_HI: begin
                if (w_xfer) w_state_next = CNT_LO;
            end
            CNT_LO: begin
                if (w_xfer) begin
                    if (32'(w_count) > DEPTH) begin
                        w_state_next = ERR;
                    end else if (w_count == 16'd0) begin
                        w_state_next = CHK;
                    end else begin
                        w_state_next = W_HI;
                    end
                end
            end
            W_HI: begin
                if (w_xfer) w_state_next = W_LO;
            end
            W_LO: begin
                if (w_xfer) w_state_next = WR;
            end
            WR: begin
                imem_we = 1'b1;
                if (w_idx_next == {1'b0, r_count}) begin
                    w_state_next = CHK;
                end else begin
                    w_state_next = W_HI;
                end
            end
            CHK: begin
                if (w_xfer) begin
                    if (rx_data == r_csum) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = ERR;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- datapath
    // Address/data are captured with the low byte so they stay stable through
    // and after the WR cycle, independent of the index increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_idx   <= '0;
            r_csum  <= '0;
            r_hi    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (w_start) begin
                        r_csum  <= '0;
                        r_idx   <= '0;
                        r_count <= '0;
                    end
                end
                CNT_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= rx_data;
                        r_csum        <= r_csum ^ rx_data;
                    end
                end
                CNT_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= rx_data;
                        r_csum       <= r_csum ^ rx_data;
                    end
                end
                W_HI: begin
                    if (w_xfer) begin
                        r_hi   <= rx_data;
                        r_csum <= r_csum ^ rx_data;
                    end
                end
                W_LO: begin
                    if (w_xfer) begin
                        r_addr  <= r_idx[15:0];
                        r_wdata <= {r_hi, rx_data};
                        r_csum  <= r_csum ^ rx_data;
                    end
                end
                WR: begin
                    r_idx <= w_idx_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;

endmodule
